// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction
// fetch (imem) and data (dmem) requesters. Only one transaction is in flight.
// The address, write data and write flag are captured at grant time so the
// memory sees stable values. Data requests win by default. A streak limit
// stops data traffic from starving fetches, and a saturating counter records
// how many idle cycles had both requesters waiting.
module mem_port_arbiter #(
  parameter int DWidth     = 32,
  parameter int MaxDStreak = 4,
  parameter int CntWidth   = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                imem_req_i,
  input  logic [DWidth-1:0]   imem_addr_i,
  output logic                imem_ready_o,
  output logic [DWidth-1:0]   imem_rdata_o,
  input  logic                dmem_req_i,
  input  logic                dmem_write_i,
  input  logic [DWidth-1:0]   dmem_addr_i,
  input  logic [DWidth-1:0]   dmem_wdata_i,
  output logic                dmem_ready_o,
  output logic [DWidth-1:0]   dmem_rdata_o,
  output logic                mem_req_o,
  output logic                mem_write_o,
  output logic [DWidth-1:0]   mem_addr_o,
  output logic [DWidth-1:0]   mem_wdata_o,
  input  logic                mem_ready_i,
  input  logic [DWidth-1:0]   mem_rdata_i,
  output logic [CntWidth-1:0] conflict_cnt_o
);

  localparam int SW = $clog2(MaxDStreak + 1);
  localparam logic [SW-1:0] MAX_STREAK = SW'(MaxDStreak);
  localparam logic [CntWidth-1:0] CNT_MAX = {CntWidth{1'b1}};

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic [SW-1:0]       streak_r;
  logic [SW-1:0]       streak_nxt_s;
  logic                req_nxt_s;
  logic                write_nxt_s;
  logic [DWidth-1:0]   addr_nxt_s;
  logic [DWidth-1:0]   wdata_nxt_s;
  logic [CntWidth-1:0] cnt_nxt_s;
  logic                both_req_s;
  logic                grant_d_s;

  assign both_req_s = imem_req_i & dmem_req_i;
  // A data request is granted unless a waiting fetch has hit the streak limit.
  assign grant_d_s  = dmem_req_i & (~imem_req_i | (streak_r < MAX_STREAK));

  // Next-state, grant latching, streak and conflict-count computation.
  always_comb begin
    state_nxt_s  = state_r;
    streak_nxt_s = streak_r;
    req_nxt_s    = mem_req_o;
    write_nxt_s  = mem_write_o;
    addr_nxt_s   = mem_addr_o;
    wdata_nxt_s  = mem_wdata_o;
    cnt_nxt_s    = conflict_cnt_o;
    case (state_r)
      IDLE: begin
        if (both_req_s && (conflict_cnt_o != CNT_MAX)) begin
          cnt_nxt_s = conflict_cnt_o + {{(CntWidth-1){1'b0}}, 1'b1};
        end else begin
          cnt_nxt_s = conflict_cnt_o;
        end
        if (grant_d_s) begin
          state_nxt_s = BUSY_D;
          req_nxt_s   = 1'b1;
          write_nxt_s = dmem_write_i;
          addr_nxt_s  = dmem_addr_i;
          wdata_nxt_s = dmem_wdata_i;
          // Only grants that overtake a waiting fetch count towards the streak.
          if (imem_req_i) begin
            streak_nxt_s = streak_r + {{(SW-1){1'b0}}, 1'b1};
          end else begin
            streak_nxt_s = {SW{1'b0}};
          end
        end else if (imem_req_i) begin
          state_nxt_s  = BUSY_I;
          req_nxt_s    = 1'b1;
          write_nxt_s  = 1'b0;
          addr_nxt_s   = imem_addr_i;
          wdata_nxt_s  = {DWidth{1'b0}};
          streak_nxt_s = {SW{1'b0}};
        end else begin
          streak_nxt_s = {SW{1'b0}};
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready_i) begin
          state_nxt_s = IDLE;
          req_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = state_r;
          req_nxt_s   = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        req_nxt_s   = 1'b0;
      end
    endcase
  end

  // State and memory-side registers; reset drops the port request at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r        <= IDLE;
      streak_r       <= {SW{1'b0}};
      mem_req_o      <= 1'b0;
      mem_write_o    <= 1'b0;
      mem_addr_o     <= {DWidth{1'b0}};
      mem_wdata_o    <= {DWidth{1'b0}};
      conflict_cnt_o <= {CntWidth{1'b0}};
    end else begin
      state_r        <= state_nxt_s;
      streak_r       <= streak_nxt_s;
      mem_req_o      <= req_nxt_s;
      mem_write_o    <= write_nxt_s;
      mem_addr_o     <= addr_nxt_s;
      mem_wdata_o    <= wdata_nxt_s;
      conflict_cnt_o <= cnt_nxt_s;
    end
  end

  // Forward completion and read data to the granted requester in the same cycle.
  always_comb begin
    imem_ready_o = 1'b0;
    imem_rdata_o = {DWidth{1'b0}};
    dmem_ready_o = 1'b0;
    dmem_rdata_o = {DWidth{1'b0}};
    if (state_r == BUSY_I) begin
      imem_ready_o = mem_ready_i;
      imem_rdata_o = mem_rdata_i;
    end else if (state_r == BUSY_D) begin
      dmem_ready_o = mem_ready_i;
      dmem_rdata_o = mem_rdata_i;
    end else begin
      imem_ready_o = 1'b0;
      dmem_ready_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (MaxDStreak=4, CntWidth=4).
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam logic [31:0] IADDR = 32'h0000_0100;
  localparam logic [31:0] DADDR = 32'h0000_4000;

  logic          clk;
  logic          rst;
  logic          imem_req, imem_ready;
  logic [DW-1:0] imem_addr, imem_rdata;
  logic          dmem_req, dmem_write, dmem_ready;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic          mem_req, mem_write, mem_ready;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [CW-1:0] conflict_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_port_arbiter #(.DWidth(DW), .MaxDStreak(4), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_i(imem_req), .imem_addr_i(imem_addr),
    .imem_ready_o(imem_ready), .imem_rdata_o(imem_rdata),
    .dmem_req_i(dmem_req), .dmem_write_i(dmem_write),
    .dmem_addr_i(dmem_addr), .dmem_wdata_i(dmem_wdata),
    .dmem_ready_o(dmem_ready), .dmem_rdata_o(dmem_rdata),
    .mem_req_o(mem_req), .mem_write_o(mem_write),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
    .conflict_cnt_o(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a port request, then complete it with rd.
  task automatic serve(input logic [31:0] rd, output logic [31:0] gaddr,
                       output logic ir, output logic dr,
                       output logic [31:0] ird, output logic [31:0] drd);
    int k;
    k = 0;
    while (!mem_req && k < 20) begin
      tick();
      k++;
    end
    check("grant_timeout", mem_req, 1'b1);
    gaddr = mem_addr;
    mem_ready = 1'b1;
    mem_rdata = rd;
    #1;
    ir  = imem_ready;
    dr  = dmem_ready;
    ird = imem_rdata;
    drd = dmem_rdata;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
  endtask

  logic [31:0] ga, ird, drd;
  logic        ir, dr, is_i;

  initial begin
    rst = 1'b1; imem_req = 1'b0; imem_addr = 32'h0;
    dmem_req = 1'b0; dmem_write = 1'b0; dmem_addr = 32'h0; dmem_wdata = 32'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_cnt", conflict_cnt, 4'h0);
    rst = 1'b0;
    tick();

    // T1: fetch read, memory answers after 3 cycles; requester drops req early.
    imem_req = 1'b1; imem_addr = IADDR;
    tick();
    check("t1_req", mem_req, 1'b1);
    check("t1_addr", mem_addr, IADDR);
    check("t1_write", mem_write, 1'b0);
    imem_req = 1'b0; imem_addr = 32'h0000_0BAD;
    tick();
    check("t1_addr_held", mem_addr, IADDR);
    check("t1_no_rdy_early", imem_ready, 1'b0);
    tick();
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("t1_irdy", imem_ready, 1'b1);
    check("t1_irdata", imem_rdata, 32'hDEAD_BEEF);
    check("t1_drdy", dmem_ready, 1'b0);
    check("t1_drdata", dmem_rdata, 32'h0);
    tick();
    mem_ready = 1'b0; mem_rdata = 32'h0;
    #1;
    check("t1_req_fall", mem_req, 1'b0);
    check("t1_irdy_fall", imem_ready, 1'b0);

    // T2: data store, memory answers after 1 cycle.
    dmem_req = 1'b1; dmem_write = 1'b1; dmem_addr = DADDR; dmem_wdata = 32'h1234_5678;
    tick();
    check("t2_write", mem_write, 1'b1);
    check("t2_wdata", mem_wdata, 32'h1234_5678);
    check("t2_addr", mem_addr, DADDR);
    mem_ready = 1'b1; mem_rdata = 32'hAAAA_5555;
    #1;
    check("t2_drdy", dmem_ready, 1'b1);
    check("t2_drdata", dmem_rdata, 32'hAAAA_5555);
    check("t2_irdy", imem_ready, 1'b0);
    dmem_req = 1'b0; dmem_write = 1'b0;
    tick();
    mem_ready = 1'b0; mem_rdata = 32'h0;
    #1;
    check("t2_req_fall", mem_req, 1'b0);
    check("t2_drdy_fall", dmem_ready, 1'b0);

    // Ready from memory while idle must not be forwarded.
    mem_ready = 1'b1;
    #1;
    check("idle_rdy_i", imem_ready, 1'b0);
    check("idle_rdy_d", dmem_ready, 1'b0);
    tick();
    mem_ready = 1'b0;
    check("idle_rdy_no_req", mem_req, 1'b0);

    // T3: both requests in the same cycle: data first, then fetch.
    imem_req = 1'b1; imem_addr = IADDR;
    dmem_req = 1'b1; dmem_addr = DADDR; dmem_wdata = 32'h0;
    tick();
    check("t3_first_addr", mem_addr, DADDR);
    check("t3_cnt", conflict_cnt, 4'h1);
    serve(32'h0000_00D1, ga, ir, dr, ird, drd);
    check("t3_d_rdy", dr, 1'b1);
    check("t3_d_rdata", drd, 32'h0000_00D1);
    dmem_req = 1'b0;
    serve(32'h0000_00E1, ga, ir, dr, ird, drd);
    check("t3_second_addr", ga, IADDR);
    check("t3_i_rdy", ir, 1'b1);
    check("t3_i_rdata", ird, 32'h0000_00E1);
    imem_req = 1'b0;
    check("t3_cnt_after", conflict_cnt, 4'h1);

    // T4: both held continuously: D,D,D,D,I,D,D,D,D,I.
    imem_req = 1'b1; dmem_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      is_i = (i == 4) || (i == 9);
      serve(32'h0000_1000 + 32'(i), ga, ir, dr, ird, drd);
      check("t4_order", ga, is_i ? IADDR : DADDR);
      check("t4_irdy", ir, is_i);
      check("t4_drdy", dr, !is_i);
      check("t4_rdata", is_i ? ird : drd, 32'h0000_1000 + 32'(i));
    end
    imem_req = 1'b0; dmem_req = 1'b0;
    check("t4_cnt", conflict_cnt, 4'hB);

    // T5: build a streak of 2, reset during the third data transaction.
    imem_req = 1'b1; dmem_req = 1'b1;
    serve(32'h1, ga, ir, dr, ird, drd);
    serve(32'h2, ga, ir, dr, ird, drd);
    tick();
    check("t5_busy_addr", mem_addr, DADDR);
    check("t5_busy_req", mem_req, 1'b1);
    rst = 1'b1; imem_req = 1'b0; dmem_req = 1'b0;
    #1;
    check("t5_async_req", mem_req, 1'b0);
    check("t5_async_cnt", conflict_cnt, 4'h0);
    tick();
    rst = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
    #1;
    check("t5_late_drdy", dmem_ready, 1'b0);
    check("t5_late_irdy", imem_ready, 1'b0);
    tick();
    mem_ready = 1'b0; mem_rdata = 32'h0;
    check("t5_req_idle", mem_req, 1'b0);
    imem_req = 1'b1; dmem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      serve(32'h0000_2000 + 32'(i), ga, ir, dr, ird, drd);
      check("t5_order", ga, (i == 4) ? IADDR : DADDR);
    end
    check("t5_cnt", conflict_cnt, 4'h5);

    // T6: 20 more conflicts saturate the 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      serve(32'h0000_3000 + 32'(i), ga, ir, dr, ird, drd);
    end
    imem_req = 1'b0; dmem_req = 1'b0;
    check("t6_sat", conflict_cnt, 4'hF);
    tick(); tick();
    check("t6_sat_hold", conflict_cnt, 4'hF);
    check("t6_idle", mem_req, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
